// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control slice.
// Contents:
//   seq_state_t        - sequencer FSM state
//   HALT_ADDR_DEFAULT  - PC value that parks the CPU
//   RESET_VECTOR       - PC value after reset, used by the PC and by benches
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALTED
  } seq_state_t;

  localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR      = 32'hBFC0_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer and its neighbours: the PC register,
// the instruction/data memory wait-requests and the branch unit.
//   master : sequencer side (drives fetch/PC control, reads status)
//   slave  : environment side (PC value, wait-requests, branch result)
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_addr;
  logic              imem_waitrequest;
  logic              dmem_access;
  logic              dmem_waitrequest;
  logic              br_valid;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;

  logic              imem_read;
  logic              instr_latch_en;
  logic              pc_state;
  logic              pc_halt;
  logic              pc_immediate;
  logic [ADDR_W-1:0] pc_target;
  logic              active;
  logic              err_branch_in_slot;

  modport master (
    input  pc_addr, imem_waitrequest, dmem_access, dmem_waitrequest,
           br_valid, br_taken, br_target,
    output imem_read, instr_latch_en, pc_state, pc_halt, pc_immediate,
           pc_target, active, err_branch_in_slot
  );

  modport slave (
    output pc_addr, imem_waitrequest, dmem_access, dmem_waitrequest,
           br_valid, br_taken, br_target,
    input  imem_read, instr_latch_en, pc_state, pc_halt, pc_immediate,
           pc_target, active, err_branch_in_slot
  );

endinterface

// File: rtl/delay_slot_buf.sv
// Branch delay-slot buffer: holds a taken target until the delay-slot
// instruction completes, and flags a taken transfer inside a delay slot.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   i_complete       - an EXEC cycle completes at this edge
//   i_taken          - completing instruction is a taken transfer
//   i_target         - its resolved target
//   o_slot_pending   - a target is waiting for the delay slot to finish
//   o_pend_target    - the waiting target
//   o_err            - sticky: taken transfer seen in a delay slot
module delay_slot_buf #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_complete,
  input  logic              i_taken,
  input  logic [ADDR_W-1:0] i_target,
  output logic              o_slot_pending,
  output logic [ADDR_W-1:0] o_pend_target,
  output logic              o_err
);

  logic              r_slot_pending;
  logic [ADDR_W-1:0] r_pend_target;
  logic              r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_pending <= 1'b0;
      r_pend_target  <= '0;
      r_err          <= 1'b0;
    end else if (i_complete) begin
      if (r_slot_pending) begin
        // Delay slot done: the held target is consumed this edge; a taken
        // transfer in the slot itself is dropped and flagged.
        r_slot_pending <= 1'b0;
        if (i_taken) r_err <= 1'b1;
      end else if (i_taken) begin
        r_slot_pending <= 1'b1;
        r_pend_target  <= i_target;
      end
    end
  end

  assign o_slot_pending = r_slot_pending;
  assign o_pend_target  = r_pend_target;
  assign o_err          = r_err;

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/EXEC controller for the program counter.
// Sequences fetches around instruction/data-memory wait-requests, applies
// taken branch targets after the delay slot, and parks the CPU at HALT_ADDR.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   bus          - pc_sequencer_if.master (PC value, wait-requests,
//                  branch result in; fetch/PC control and status out)
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(HALT_ADDR_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset_n,
  pc_sequencer_if.master  bus
);

  seq_state_t        r_state;
  seq_state_t        w_next;

  logic              w_complete;
  logic              w_taken;
  logic              w_slot_pending;
  logic [ADDR_W-1:0] w_pend_target;
  logic              w_err;

  logic              w_imem_read;
  logic              w_instr_latch_en;
  logic              w_pc_state;
  logic              w_pc_halt;
  logic              w_pc_immediate;
  logic [ADDR_W-1:0] w_pc_target;
  logic              w_active;

  assign w_taken = bus.br_valid & bus.br_taken;

  delay_slot_buf #(
    .ADDR_W (ADDR_W)
  ) u_slot (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_complete     (w_complete),
    .i_taken        (w_taken),
    .i_target       (bus.br_target),
    .o_slot_pending (w_slot_pending),
    .o_pend_target  (w_pend_target),
    .o_err          (w_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    w_complete       = 1'b0;
    w_imem_read      = 1'b0;
    w_instr_latch_en = 1'b0;
    w_pc_state       = 1'b0;
    w_pc_halt        = 1'b0;
    w_pc_immediate   = 1'b0;
    w_pc_target      = '0;
    w_active         = 1'b1;

    unique case (r_state)
      S_FETCH: begin
        if (bus.pc_addr == HALT_ADDR) begin
          w_pc_halt = 1'b1;
          w_next    = S_HALTED;
        end else begin
          w_imem_read = 1'b1;
          if (!bus.imem_waitrequest) begin
            w_instr_latch_en = 1'b1;
            w_next           = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        w_pc_state = 1'b1;
        if (bus.dmem_access && bus.dmem_waitrequest) begin
          w_pc_halt = 1'b1;
        end else begin
          w_complete = 1'b1;
          w_next     = S_FETCH;
          if (w_slot_pending) begin
            w_pc_immediate = 1'b1;
            w_pc_target    = w_pend_target;
          end
        end
      end
      S_HALTED: begin
        w_pc_halt = 1'b1;
        w_active  = 1'b0;
      end
      default: w_next = S_FETCH;
    endcase

    // Outputs follow the reset values as soon as reset_n drops, without
    // waiting for the registered state to settle.
    if (!reset_n) begin
      w_complete       = 1'b0;
      w_imem_read      = 1'b1;
      w_instr_latch_en = 1'b0;
      w_pc_state       = 1'b0;
      w_pc_halt        = 1'b0;
      w_pc_immediate   = 1'b0;
      w_pc_target      = '0;
      w_active         = 1'b1;
    end
  end

  assign bus.imem_read          = w_imem_read;
  assign bus.instr_latch_en     = w_instr_latch_en;
  assign bus.pc_state           = w_pc_state;
  assign bus.pc_halt            = w_pc_halt;
  assign bus.pc_immediate       = w_pc_immediate;
  assign bus.pc_target          = w_pc_target;
  assign bus.active             = w_active;
  assign bus.err_branch_in_slot = w_err;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import cpu_ctrl_pkg::*;

  localparam logic [31:0] HALT = HALT_ADDR_DEFAULT;
  localparam logic [31:0] RV   = RESET_VECTOR;
  localparam int PH_FETCH = 0;
  localparam int PH_EXEC  = 1;
  localparam int PH_HALT  = 2;
  // {imem_read, latch, pc_state, pc_halt, pc_immediate, active, err, pc_target}
  localparam logic [38:0] RESET_OUT = {7'b1000010, 32'h0};

  typedef struct {
    logic        iw, da, dw, bv, bt;
    logic [31:0] pc, tgt;
  } stim_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: phase of the instruction cycle, queue of targets
  // waiting for their delay slot, sticky error.
  int          m_phase;
  logic [31:0] m_pend[$];
  logic        m_err;

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(
    .ADDR_W    (32),
    .HALT_ADDR (HALT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [38:0] act();
    return {bus.imem_read, bus.instr_latch_en, bus.pc_state, bus.pc_halt,
            bus.pc_immediate, bus.active, bus.err_branch_in_slot, bus.pc_target};
  endfunction

  function automatic stim_t mk(input logic iw, da, dw, bv, bt,
                               input logic [31:0] pc, tgt);
    stim_t s;
    s.iw = iw; s.da = da; s.dw = dw; s.bv = bv; s.bt = bt; s.pc = pc; s.tgt = tgt;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.imem_waitrequest = s.iw;
    bus.dmem_access      = s.da;
    bus.dmem_waitrequest = s.dw;
    bus.br_valid         = s.bv;
    bus.br_taken         = s.bt;
    bus.pc_addr          = s.pc;
    bus.br_target        = s.tgt;
  endtask

  function automatic void model_reset();
    m_phase = PH_FETCH;
    m_pend.delete();
    m_err = 1'b0;
  endfunction

  // Expected outputs and a mask of the fields defined in the current phase.
  function automatic void model_expect(output logic [38:0] e, output logic [38:0] m);
    logic ir, le, ps, ph, im, ac, mi, ml, mt;
    logic [31:0] tg;
    ir = 0; le = 0; ps = 0; ph = 0; im = 0; ac = 1; tg = '0;
    mi = 1; ml = 1; mt = 0;
    case (m_phase)
      PH_FETCH: begin
        if (bus.pc_addr == HALT) ph = 1;
        else begin ir = 1; le = !bus.imem_waitrequest; end
      end
      PH_EXEC: begin
        ps = 1; mi = 0; ml = 0;
        if (bus.dmem_access && bus.dmem_waitrequest) ph = 1;
        else begin
          mt = 1;
          if (m_pend.size() != 0) begin im = 1; tg = m_pend[0]; end
        end
      end
      default: begin ph = 1; ac = 0; end
    endcase
    e = {ir, le, ps, ph, im, ac, m_err, tg};
    m = {mi, ml, 5'b11111, {32{mt}}};
  endfunction

  function automatic void model_advance();
    logic taken;
    taken = bus.br_valid && bus.br_taken;
    case (m_phase)
      PH_FETCH: begin
        if (bus.pc_addr == HALT) m_phase = PH_HALT;
        else if (!bus.imem_waitrequest) m_phase = PH_EXEC;
      end
      PH_EXEC: begin
        if (!(bus.dmem_access && bus.dmem_waitrequest)) begin
          if (m_pend.size() != 0) begin
            void'(m_pend.pop_front());
            if (taken) m_err = 1'b1;
          end else if (taken) begin
            m_pend.push_back(bus.br_target);
          end
          m_phase = PH_FETCH;
        end
      end
      default: ;
    endcase
  endfunction

  // Called at a falling edge; returns at the next falling edge, out of reset.
  task automatic do_reset();
    reset_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, RV, 32'h0));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, HALT, 32'h0));
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (act() !== RESET_OUT)
      begin n_fail++; $display("FAIL reset_at_halt_addr: got %h want %h", act(), RESET_OUT); end
    drive(mk(0, 1, 1, 1, 1, RV, 32'h1234));
    #1;
    n_tests++;
    if (act() !== RESET_OUT)
      begin n_fail++; $display("FAIL reset_busy_inputs: got %h want %h", act(), RESET_OUT); end
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_fetch_exec();
    logic [38:0] e, m;
    logic [5:0] ps_seen, le_seen;
    for (int i = 0; i < 6; i++) begin
      drive(mk(0, 0, 0, 0, 0, RV + 32'(i * 2), 32'h0));
      #1; model_expect(e, m); n_tests++;
      if ((act() & m) !== (e & m))
        begin n_fail++; $display("FAIL fetch_exec cyc%0d: got %h want %h", i, act() & m, e & m); end
      ps_seen[i] = bus.pc_state;
      le_seen[i] = bus.instr_latch_en;
      model_advance(); @(negedge clk);
    end
    n_tests++;
    if ({ps_seen, le_seen} !== {6'b101010, 6'b010101})
      begin n_fail++; $display("FAIL fetch_exec_pattern: got %b/%b want 101010/010101", ps_seen, le_seen); end
  endtask

  task automatic test_imem_stall();
    logic [38:0] e, m;
    int latches, reads;
    do_reset();
    latches = 0; reads = 0;
    for (int i = 0; i < 4; i++) begin
      drive(mk(i < 3, 0, 0, 0, 0, RV, 32'h0));
      #1; model_expect(e, m); n_tests++;
      if ((act() & m) !== (e & m))
        begin n_fail++; $display("FAIL imem_stall cyc%0d: got %h want %h", i, act() & m, e & m); end
      latches += int'(bus.instr_latch_en);
      reads   += int'(bus.imem_read);
      model_advance(); @(negedge clk);
    end
    n_tests++;
    if (latches != 1 || reads != 4 || bus.pc_state !== 1'b1)
      begin n_fail++; $display("FAIL imem_stall_summary: got latch=%0d read=%0d st=%b want 1/4/1", latches, reads, bus.pc_state); end
  endtask

  task automatic test_branch_slot();
    logic [38:0] e, m;
    stim_t q[$];
    logic [32:0] slot_out, after_out;
    do_reset();
    q.push_back(mk(0, 0, 0, 0, 0, RV, 32'h0));
    q.push_back(mk(0, 0, 0, 1, 1, RV, 32'hBFC0_0100));
    q.push_back(mk(0, 0, 0, 0, 0, RV + 4, 32'h0));
    q.push_back(mk(0, 0, 0, 1, 0, RV + 4, 32'hDEAD_0000));
    q.push_back(mk(0, 0, 0, 0, 0, 32'hBFC0_0100, 32'h0));
    q.push_back(mk(0, 0, 0, 0, 0, 32'hBFC0_0100, 32'h0));
    foreach (q[i]) begin
      drive(q[i]);
      #1; model_expect(e, m); n_tests++;
      if ((act() & m) !== (e & m))
        begin n_fail++; $display("FAIL branch_slot cyc%0d: got %h want %h", i, act() & m, e & m); end
      if (i == 3) slot_out  = {bus.pc_immediate, bus.pc_target};
      if (i == 5) after_out = {bus.pc_immediate, bus.pc_target};
      model_advance(); @(negedge clk);
    end
    n_tests++;
    if (slot_out !== {1'b1, 32'hBFC0_0100})
      begin n_fail++; $display("FAIL branch_slot_apply: got %h want %h", slot_out, {1'b1, 32'hBFC0_0100}); end
    n_tests++;
    if (after_out !== 33'h0)
      begin n_fail++; $display("FAIL branch_after_slot: got %h want 0", after_out); end
  endtask

  task automatic test_dmem_stall_slot();
    logic [38:0] e, m;
    stim_t q[$];
    logic [3:0] stall_seen;
    logic [32:0] done_out;
    logic late;
    do_reset();
    q.push_back(mk(0, 0, 0, 0, 0, RV, 32'h0));
    q.push_back(mk(0, 0, 0, 1, 1, RV, 32'hBFC0_0100));
    q.push_back(mk(0, 0, 0, 0, 0, RV + 4, 32'h0));
    q.push_back(mk(0, 1, 1, 1, 1, RV + 4, 32'hBFC0_0200));
    q.push_back(mk(0, 1, 1, 1, 1, RV + 4, 32'hBFC0_0200));
    q.push_back(mk(0, 1, 0, 0, 0, RV + 4, 32'h0));
    q.push_back(mk(0, 0, 0, 0, 0, 32'hBFC0_0100, 32'h0));
    q.push_back(mk(0, 0, 0, 0, 0, 32'hBFC0_0100, 32'h0));
    foreach (q[i]) begin
      drive(q[i]);
      #1; model_expect(e, m); n_tests++;
      if ((act() & m) !== (e & m))
        begin n_fail++; $display("FAIL dmem_stall cyc%0d: got %h want %h", i, act() & m, e & m); end
      if (i == 3) stall_seen[3:2] = {bus.pc_halt, bus.pc_immediate};
      if (i == 4) stall_seen[1:0] = {bus.pc_halt, bus.pc_immediate};
      if (i == 5) done_out = {bus.pc_immediate, bus.pc_target};
      if (i == 7) late = bus.pc_immediate | bus.err_branch_in_slot;
      model_advance(); @(negedge clk);
    end
    n_tests++;
    if (stall_seen !== 4'b1010)
      begin n_fail++; $display("FAIL dmem_stall_hold: got %b want 1010", stall_seen); end
    n_tests++;
    if (done_out !== {1'b1, 32'hBFC0_0100})
      begin n_fail++; $display("FAIL dmem_stall_apply: got %h want %h", done_out, {1'b1, 32'hBFC0_0100}); end
    n_tests++;
    if (late !== 1'b0)
      begin n_fail++; $display("FAIL dmem_stall_branch_ignored: got %b want 0", late); end
  endtask

  task automatic test_halt();
    logic [38:0] e, m;
    stim_t q[$];
    logic [1:0] halt_fetch;
    int parked;
    do_reset();
    q.push_back(mk(0, 0, 0, 0, 0, RV, 32'h0));
    q.push_back(mk(0, 0, 0, 1, 1, RV, HALT));
    q.push_back(mk(0, 0, 0, 0, 0, RV + 4, 32'h0));
    q.push_back(mk(0, 0, 0, 0, 0, RV + 4, 32'h0));
    q.push_back(mk(0, 0, 0, 0, 0, HALT, 32'h0));
    foreach (q[i]) begin
      drive(q[i]);
      #1; model_expect(e, m); n_tests++;
      if ((act() & m) !== (e & m))
        begin n_fail++; $display("FAIL halt_seq cyc%0d: got %h want %h", i, act() & m, e & m); end
      if (i == 4) halt_fetch = {bus.imem_read, bus.pc_halt};
      model_advance(); @(negedge clk);
    end
    n_tests++;
    if (halt_fetch !== 2'b01)
      begin n_fail++; $display("FAIL halt_detect: got read/halt=%b want 01", halt_fetch); end
    parked = 0;
    for (int i = 0; i < 22; i++) begin
      drive(mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               RV + 32'($urandom_range(1, 100) * 4), $urandom));
      #1; model_expect(e, m); n_tests++;
      if ((act() & m) !== (e & m))
        begin n_fail++; $display("FAIL halted cyc%0d: got %h want %h", i, act() & m, e & m); end
      if (!bus.active && bus.pc_halt && !bus.imem_read) parked++;
      model_advance(); @(negedge clk);
    end
    n_tests++;
    if (parked != 22)
      begin n_fail++; $display("FAIL halted_sticky: got %0d parked cycles want 22", parked); end
    reset_n = 1'b0;
    #1; n_tests++;
    if (act() !== RESET_OUT)
      begin n_fail++; $display("FAIL halt_reset_release: got %h want %h", act(), RESET_OUT); end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_branch_in_slot();
    logic [38:0] e, m;
    stim_t q[$];
    logic [33:0] slot_out;
    logic err_seen;
    do_reset();
    q.push_back(mk(0, 0, 0, 0, 0, RV, 32'h0));
    q.push_back(mk(0, 0, 0, 1, 1, RV, 32'hBFC0_0100));
    q.push_back(mk(0, 0, 0, 0, 0, RV + 4, 32'h0));
    q.push_back(mk(0, 0, 0, 1, 1, RV + 4, 32'hBFC0_0200));
    q.push_back(mk(0, 0, 0, 0, 0, 32'hBFC0_0100, 32'h0));
    q.push_back(mk(0, 0, 0, 0, 0, 32'hBFC0_0100, 32'h0));
    q.push_back(mk(0, 0, 0, 0, 0, 32'hBFC0_0104, 32'h0));
    q.push_back(mk(0, 0, 0, 1, 1, 32'hBFC0_0104, 32'hBFC0_0300));
    q.push_back(mk(0, 0, 0, 0, 0, 32'hBFC0_0108, 32'h0));
    foreach (q[i]) begin
      drive(q[i]);
      #1; model_expect(e, m); n_tests++;
      if ((act() & m) !== (e & m))
        begin n_fail++; $display("FAIL slot_branch cyc%0d: got %h want %h", i, act() & m, e & m); end
      if (i == 3) slot_out = {bus.pc_immediate, bus.err_branch_in_slot, bus.pc_target};
      if (i == 4) err_seen = bus.err_branch_in_slot;
      model_advance(); @(negedge clk);
    end
    n_tests++;
    if (slot_out !== {2'b10, 32'hBFC0_0100} || err_seen !== 1'b1)
      begin n_fail++; $display("FAIL slot_branch_ignored: got %h err=%b want %h err=1", slot_out, err_seen, {2'b10, 32'hBFC0_0100}); end
    // Now in EXEC with 0xBFC00300 pending and the error set: reset mid-cycle.
    drive(mk(0, 0, 0, 0, 0, 32'hBFC0_0108, 32'h0));
    #2; reset_n = 1'b0;
    #1; n_tests++;
    if (act() !== RESET_OUT)
      begin n_fail++; $display("FAIL async_reset: got %h want %h", act(), RESET_OUT); end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(mk(0, 0, 0, 0, 0, RV, 32'h0));
      #1; model_expect(e, m); n_tests++;
      if ((act() & m) !== (e & m))
        begin n_fail++; $display("FAIL post_reset cyc%0d: got %h want %h", i, act() & m, e & m); end
      if (i == 1) begin
        n_tests++;
        if ({bus.pc_state, bus.pc_immediate} !== 2'b10)
          begin n_fail++; $display("FAIL pending_discarded: got st/imm=%b want 10", {bus.pc_state, bus.pc_immediate}); end
      end
      model_advance(); @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [38:0] e, m;
    stim_t s;
    int parked;
    do_reset();
    parked = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_phase == PH_HALT && parked > 3) begin
        do_reset();
        parked = 0;
      end
      s = mk($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 6,
             ($urandom_range(0, 29) == 0) ? HALT : RV + 32'($urandom_range(0, 1023) * 4),
             $urandom);
      drive(s);
      #1; model_expect(e, m); n_tests++;
      if ((act() & m) !== (e & m))
        begin n_fail++; $display("FAIL random cyc%0d: got %h want %h", i, act() & m, e & m); end
      if (m_phase == PH_HALT) parked++;
      model_advance(); @(negedge clk);
    end
  endtask

  initial begin
    drive(mk(0, 0, 0, 0, 0, RV, 32'h0));
    model_reset();
    test_reset();
    test_fetch_exec();
    test_imem_stall();
    test_branch_slot();
    test_dmem_stall_slot();
    test_halt();
    test_branch_in_slot();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
